// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue: circular buffer of DEPTH {instr, PC, PC+4, arm} entries.
// Optional macro ARM_MODE_EN stores the per-entry ARM/Thumb-set bit; otherwise armD is tied low.
module fd_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     validF,
    input  logic [XLEN-1:0]          RDD,
    input  logic [XLEN-1:0]          PCF,
    input  logic [XLEN-1:0]          PCPlus4F,
    input  logic                     armF,
    output logic                     readyF,
    output logic                     validD,
    output logic [XLEN-1:0]          instrD,
    output logic [XLEN-1:0]          PCD,
    output logic [XLEN-1:0]          PCPlus4D,
    output logic                     armD,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic [$clog2(DEPTH):0]   countD
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] pc4_mem   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign readyF = (count < FULL);
    assign validD = (count != '0);
    assign countD = count;
    assign push   = validF & readyF & ~FlushD;
    assign pop    = validD & ~StallD & ~FlushD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (FlushD) begin
            // Flush wins over stall and drops the entry offered this cycle.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= RDD;
            pc_mem[wr_ptr]    <= PCF;
            pc4_mem[wr_ptr]   <= PCPlus4F;
        end
    end

    always_comb begin
        instrD   = '0;
        PCD      = '0;
        PCPlus4D = '0;
        if (validD) begin
            instrD   = instr_mem[rd_ptr];
            PCD      = pc_mem[rd_ptr];
            PCPlus4D = pc4_mem[rd_ptr];
        end
    end

`ifdef ARM_MODE_EN
    logic arm_mem [DEPTH];
    logic arm_last;

    always_ff @(posedge clk) begin
        if (push) arm_mem[wr_ptr] <= armF;
    end

    // arm_last keeps armD at the last popped value while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            arm_last <= 1'b0;
        else if (pop)
            arm_last <= arm_mem[rd_ptr];
    end

    assign armD = validD ? arm_mem[rd_ptr] : arm_last;
`else
    logic unused_armF;
    assign unused_armF = armF;
    assign armD        = 1'b0;
`endif

endmodule
